snake_dir_ctrl: RTL and testbench

// - Consumes the single-cycle pulses from the four button Debouncers and turns them into the snake's registered heading.
// - Buffers up to QUEUE_DEPTH pending turns and validates each one (no null turn, no 180-degree reversal).
// - Applies one queued turn per game step_tick. Feeds the snake-body/movement engine.

---
 rtl/snake_dir_ctrl_pkg.sv | 25 ++
 rtl/snake_dir_ctrl_if.sv | 28 ++
 rtl/snake_dir_ctrl_dir_fifo.sv | 88 ++++++++
 rtl/snake_dir_ctrl.sv | 109 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
// Shared definitions for the snake heading controller: direction codes,
// widths, the decoded button request record and the reversal helper.
package snake_dir_ctrl_pkg;

    localparam int DIR_W = 2;
    localparam int CNT_W = 3;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b11;

    // Result of the fixed-priority button arbiter for one cycle.
    typedef struct packed {
        logic             valid;   // at least one button pulsed
        logic [DIR_W-1:0] dir;     // winning direction
        logic             others;  // a lower-priority button was also pulsed
    } req_t;

    // Heading that would turn the snake back onto itself.
    function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button/strobe inputs and heading/status outputs of the heading controller.
interface snake_dir_ctrl_if;
    import snake_dir_ctrl_pkg::*;

    logic             restart;
    logic             enable;
    logic             btn_up;
    logic             btn_right;
    logic             btn_down;
    logic             btn_left;
    logic             step_tick;
    logic [DIR_W-1:0] dir;
    logic             turn_applied;
    logic             req_rejected;
    logic             req_dropped;
    logic [CNT_W-1:0] queue_count;

    modport master (
        output restart, enable, btn_up, btn_right, btn_down, btn_left, step_tick,
        input  dir, turn_applied, req_rejected, req_dropped, queue_count
    );

    modport slave (
        input  restart, enable, btn_up, btn_right, btn_down, btn_left, step_tick,
        output dir, turn_applied, req_rejected, req_dropped, queue_count
    );

endinterface

// File: rtl/snake_dir_ctrl_dir_fifo.sv
// Small queue of pending 2-bit headings. Entry 0 is always the head; a pop
// shifts everything down one slot. Push and pop may coincide, including
// when full, in which case the count is unchanged.
module dir_fifo
    import snake_dir_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DIR_W-1:0] i_din,
    output logic [DIR_W-1:0] o_head,
    output logic [DIR_W-1:0] o_tail,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [DEPTH*DIR_W-1:0] r_mem;
    logic [CNT_W-1:0]       r_count;

    logic                   w_do_push;
    logic                   w_do_pop;
    logic [DEPTH*DIR_W-1:0] w_shifted;
    logic [DEPTH*DIR_W-1:0] w_mem_nxt;
    logic [CNT_W-1:0]       w_wr_idx;
    logic [CNT_W-1:0]       w_count_nxt;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[DIR_W-1:0];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Select the newest entry (slot count-1); slot 0 when empty is a don't-care.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_tail = r_mem[DIR_W-1:0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_count == CNT_W'(i + 1)) begin
                o_tail = r_mem[i*DIR_W +: DIR_W];
            end
        end
    end

    // Next storage image: shift on pop, then drop the new entry just past the survivors.
    always_comb begin
        w_shifted = w_do_pop ? (r_mem >> DIR_W) : r_mem;
        w_wr_idx  = w_do_pop ? (r_count - CNT_W'(1)) : r_count;
        w_mem_nxt = w_shifted;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (w_wr_idx == CNT_W'(i))) begin
                w_mem_nxt[i*DIR_W +: DIR_W] = i_din;
            end
        end
    end

    // Occupancy bookkeeping.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Occupancy register; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count alone defines which slots hold valid entries.
        r_mem <= w_mem_nxt;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced button pulses into the snake's registered heading.
// Requests are arbitrated (up > right > down > left), validated against the
// newest pending heading, queued, and applied one per game step.
module snake_dir_ctrl
    import snake_dir_ctrl_pkg::*;
#(
    parameter int               QUEUE_DEPTH = 2,
    parameter logic [DIR_W-1:0] RESET_DIR   = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    snake_dir_ctrl_if.slave  bus
);

    logic [DIR_W-1:0] r_dir;
    logic             r_turn_applied;
    logic             r_req_rejected;
    logic             r_req_dropped;

    req_t             w_req;
    logic [DIR_W-1:0] w_head;
    logic [DIR_W-1:0] w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [DIR_W-1:0] w_ref;
    logic             w_bad_turn;
    logic             w_accept;
    logic             w_pop;
    logic             w_pop_eff;
    logic             w_room;
    logic             w_push;
    logic             w_rej_nxt;
    logic             w_drop_nxt;

    // Fixed-priority arbiter: only the highest-priority pulse is evaluated.
    always_comb begin
        w_req = '0;
        if (bus.btn_up) begin
            w_req.valid  = 1'b1;
            w_req.dir    = DIR_UP;
            w_req.others = bus.btn_right | bus.btn_down | bus.btn_left;
        end else if (bus.btn_right) begin
            w_req.valid  = 1'b1;
            w_req.dir    = DIR_RIGHT;
            w_req.others = bus.btn_down | bus.btn_left;
        end else if (bus.btn_down) begin
            w_req.valid  = 1'b1;
            w_req.dir    = DIR_DOWN;
            w_req.others = bus.btn_left;
        end else if (bus.btn_left) begin
            w_req.valid  = 1'b1;
            w_req.dir    = DIR_LEFT;
        end
    end

    // Validate against the heading the snake will have when this turn is applied.
    assign w_ref      = w_empty ? r_dir : w_tail;
    assign w_bad_turn = (w_req.dir == w_ref) || (w_req.dir == opposite(w_ref));
    assign w_accept   = bus.enable && w_req.valid && !w_bad_turn;

    // A same-edge pop frees a slot, so a full queue can still take the push.
    assign w_pop      = bus.enable && bus.step_tick;
    assign w_pop_eff  = w_pop && !w_empty;
    assign w_room     = !w_full || w_pop_eff;
    assign w_push     = w_accept && w_room;
    assign w_rej_nxt  = bus.enable && w_req.valid && w_bad_turn;
    assign w_drop_nxt = bus.enable && (w_req.others || (w_accept && !w_room));

    dir_fifo #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.restart),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_req.dir),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Heading register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst || bus.restart) begin
            r_dir          <= RESET_DIR;
            r_turn_applied <= 1'b0;
            r_req_rejected <= 1'b0;
            r_req_dropped  <= 1'b0;
        end else begin
            if (w_pop_eff) begin
                r_dir <= w_head;
            end
            r_turn_applied <= w_pop_eff;
            r_req_rejected <= w_rej_nxt;
            r_req_dropped  <= w_drop_nxt;
        end
    end

    assign bus.dir          = r_dir;
    assign bus.turn_applied = r_turn_applied;
    assign bus.req_rejected = r_req_rejected;
    assign bus.req_dropped  = r_req_dropped;
    assign bus.queue_count  = w_count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: reset, turn latency, a cycle-by-cycle
// vector table for validation/queue/priority behaviour, and reset dominance.
module tb_snake_dir_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    snake_dir_ctrl_if bus();

    snake_dir_ctrl #(
        .QUEUE_DEPTH (2),
        .RESET_DIR   (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one clock, outputs expected just after that edge.
    typedef struct {
        logic       restart;
        logic       enable;
        logic [3:0] btn;      // {up, right, down, left}
        logic       tick;
        logic [1:0] dir;
        logic       ta;
        logic       rej;
        logic       drop;
        logic [2:0] cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic en, input logic [3:0] b, input logic tk);
        bus.restart   = rs;
        bus.enable    = en;
        bus.btn_up    = b[3];
        bus.btn_right = b[2];
        bus.btn_down  = b[1];
        bus.btn_left  = b[0];
        bus.step_tick = tk;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] d, input logic ta,
                              input logic rej, input logic drop, input logic [2:0] c);
        check($sformatf("%s.dir", tag), 32'(bus.dir), 32'(d));
        check($sformatf("%s.turn_applied", tag), 32'(bus.turn_applied), 32'(ta));
        check($sformatf("%s.req_rejected", tag), 32'(bus.req_rejected), 32'(rej));
        check($sformatf("%s.req_dropped", tag), 32'(bus.req_dropped), 32'(drop));
        check($sformatf("%s.queue_count", tag), 32'(bus.queue_count), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //          rs    en    btn      tick  dir    ta    rej   drop  cnt
        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0}; // restart
        vecs[1]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 3'd0}; // left = reversal
        vecs[2]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 3'd0}; // right = null
        vecs[3]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0}; // idle
        vecs[4]  = '{1'b0, 1'b1, 4'b1000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd1}; // up queued
        vecs[5]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd2}; // left vs tail up
        vecs[6]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 3'd2}; // down, queue full
        vecs[7]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1}; // tick -> up
        vecs[8]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 3'd0}; // tick -> left
        vecs[9]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0}; // tick, empty
        vecs[10] = '{1'b0, 1'b1, 4'b1010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 3'd1}; // up+down: up wins
        vecs[11] = '{1'b0, 1'b1, 4'b0100, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 3'd2}; // right vs tail up
        vecs[12] = '{1'b0, 1'b1, 4'b0010, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'd2}; // full: push+pop
        vecs[13] = '{1'b0, 1'b0, 4'b1000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd2}; // disabled: hold
        vecs[14] = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0}; // restart, 2 pending
        vecs[15] = '{1'b0, 1'b1, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0}; // tick after restart
        vecs[16] = '{1'b0, 1'b1, 4'b1000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'd1}; // up on tick, no bypass
        vecs[17] = '{1'b0, 1'b1, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0}; // applied next tick
        vecs[18] = '{1'b0, 1'b1, 4'b0010, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0}; // reversal on tick
        vecs[19] = '{1'b0, 1'b1, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'd0}; // all four buttons
        vecs[20] = '{1'b0, 1'b0, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0}; // disabled button
        vecs[21] = '{1'b0, 1'b1, 4'b0100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1}; // right queued

        // Reset held for two cycles, then three idle cycles.
        rst = 1'b1;
        drive(1'b0, 1'b1, 4'b0000, 1'b0);
        cycle();
        cycle();
        check_outs("in_reset", 2'b01, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_outs($sformatf("post_reset%0d", i), 2'b01, 1'b0, 1'b0, 1'b0, 3'd0);
        end

        // Turn then tick: up pulse, tick five cycles later.
        drive(1'b0, 1'b1, 4'b1000, 1'b0);
        cycle();
        check_outs("turn_pulse", 2'b01, 1'b0, 1'b0, 1'b0, 3'd1);
        drive(1'b0, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        check_outs("turn_wait", 2'b01, 1'b0, 1'b0, 1'b0, 3'd1);
        drive(1'b0, 1'b1, 4'b0000, 1'b1);
        cycle();
        check_outs("turn_tick", 2'b00, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 4'b0000, 1'b0);
        cycle();
        check_outs("turn_after", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].restart, vecs[i].enable, vecs[i].btn, vecs[i].tick);
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].dir, vecs[i].ta,
                       vecs[i].rej, vecs[i].drop, vecs[i].cnt);
        end

        // rst dominates a same-cycle restart and button, and discards the pending turn.
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'b0001, 1'b1);
        cycle();
        check_outs("mid_rst", 2'b01, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'b0000, 1'b1);
        cycle();
        check_outs("rst_then_tick", 2'b01, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 4'b0000, 1'b0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
